cvp_boot_loader: RTL and testbench

//  Upstream of the CVP14 core: loads a program/data image from a byte stream into the shared
//  16-bit memory while holding the core in reset, then hands the memory port to the core.

---
 rtl/cvp_boot_loader_pkg.sv | 28 ++
 rtl/cvp_frame_rx.sv | 114 +++++++++++
 rtl/cvp_boot_loader.sv | 77 +++++++
 tb/tb_cvp_boot_loader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvp_boot_loader_pkg.sv
// Shared definitions for the CVP14 boot loader: state encodings, default
// framing constants and a helper describing when the byte stream is open.
package cvp_boot_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_ADDR_H = 4'd1,
    ST_ADDR_L = 4'd2,
    ST_CNT_H  = 4'd3,
    ST_CNT_L  = 4'd4,
    ST_DATA_H = 4'd5,
    ST_DATA_L = 4'd6,
    ST_CSUM   = 4'd7,
    ST_HOLD   = 4'd8,
    ST_RUN    = 4'd9,
    ST_ERR    = 4'd10
  } state_t;

  localparam logic [7:0]  SYNC_BYTE_DEFAULT   = 8'hA5;
  localparam int unsigned HOLD_CYCLES_DEFAULT = 4;
  localparam logic [15:0] CNT_GO              = 16'h0000;

  // The stream is closed only while the core is being released or is running.
  function automatic logic stream_open(input state_t s);
    return !((s == ST_HOLD) || (s == ST_RUN));
  endfunction

endpackage

// File: rtl/cvp_frame_rx.sv
// Byte-stream frame parser: tracks frame fields, accumulates the XOR checksum
// and issues one-cycle memory write strobes for each received data word.
module cvp_frame_rx
  import cvp_boot_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        hold_done,
  output logic        in_ready,
  output state_t      state,
  output logic [15:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        wr_en,
  output logic        error
);

  state_t      state_next;
  logic        accept;
  logic [15:0] addr;
  logic [15:0] cnt;
  logic [15:0] remaining;
  logic [7:0]  data_hi;
  logic [7:0]  checksum;

  assign in_ready = stream_open(state);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ERR: if (accept && (in_data == SYNC_BYTE)) state_next = ST_ADDR_H;
      ST_ADDR_H:       if (accept) state_next = ST_ADDR_L;
      ST_ADDR_L:       if (accept) state_next = ST_CNT_H;
      ST_CNT_H:        if (accept) state_next = ST_CNT_L;
      ST_CNT_L:
        if (accept) state_next = ({cnt[15:8], in_data} == CNT_GO) ? ST_CSUM : ST_DATA_H;
      ST_DATA_H:       if (accept) state_next = ST_DATA_L;
      ST_DATA_L:
        if (accept) state_next = (remaining == 16'd1) ? ST_CSUM : ST_DATA_H;
      ST_CSUM:
        if (accept) begin
          if (in_data != checksum)  state_next = ST_ERR;
          else if (cnt == CNT_GO)   state_next = ST_HOLD;
          else                      state_next = ST_IDLE;
        end
      ST_HOLD:         if (hold_done) state_next = ST_RUN;
      ST_RUN:          state_next = ST_RUN;
      default:         state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      cnt       <= '0;
      remaining <= '0;
      data_hi   <= '0;
      checksum  <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE, ST_ERR: if (in_data == SYNC_BYTE) checksum <= '0;
          ST_ADDR_H: begin
            addr[15:8] <= in_data;
            checksum   <= checksum ^ in_data;
          end
          ST_ADDR_L: begin
            addr[7:0] <= in_data;
            checksum  <= checksum ^ in_data;
          end
          ST_CNT_H: begin
            cnt[15:8] <= in_data;
            checksum  <= checksum ^ in_data;
          end
          ST_CNT_L: begin
            cnt[7:0]  <= in_data;
            remaining <= {cnt[15:8], in_data};
            checksum  <= checksum ^ in_data;
          end
          ST_DATA_H: begin
            data_hi  <= in_data;
            checksum <= checksum ^ in_data;
          end
          ST_DATA_L: begin
            // Address increment wraps naturally at 16 bits.
            wr_en     <= 1'b1;
            wr_addr   <= addr;
            wr_data   <= {data_hi, in_data};
            addr      <= addr + 16'd1;
            remaining <= remaining - 16'd1;
            checksum  <= checksum ^ in_data;
          end
          ST_CSUM: if (in_data != checksum) error <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/cvp_boot_loader.sv
// CVP14 boot loader top: frame parser, post-load hold counter, core reset/done
// control and the loader/core memory-port multiplexer.
module cvp_boot_loader
  import cvp_boot_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [15:0] CoreAddr,
  input  logic        CoreRD,
  input  logic        CoreWR,
  input  logic [15:0] CoreDataOut,
  output logic [15:0] MemAddr,
  output logic        MemRD,
  output logic        MemWR,
  output logic [15:0] MemDataOut,
  output logic        CoreReset,
  output logic        Done,
  output logic        Error
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t      state;
  logic        hold_done;
  logic [7:0]  hold_cnt;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        run;

  cvp_frame_rx #(.SYNC_BYTE(SYNC_BYTE)) u_frame_rx (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .hold_done (hold_done),
    .in_ready  (in_ready),
    .state     (state),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .error     (Error)
  );

  // Counts cycles spent in HOLD; the last one releases the core on the next edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)              hold_cnt <= '0;
    else if (state == ST_HOLD) hold_cnt <= hold_cnt + 8'd1;
    else                       hold_cnt <= '0;
  end

  assign hold_done = (state == ST_HOLD) && (hold_cnt == HOLD_LAST);
  assign run       = (state == ST_RUN);
  assign CoreReset = !run;
  assign Done      = run;

  // The core owns the port combinationally once running so its timing is untouched.
  always_comb begin
    MemAddr    = wr_addr;
    MemRD      = 1'b0;
    MemWR      = wr_en;
    MemDataOut = wr_data;
    if (run) begin
      MemAddr    = CoreAddr;
      MemRD      = CoreRD;
      MemWR      = CoreWR;
      MemDataOut = CoreDataOut;
    end
  end

endmodule

// File: tb/tb_cvp_boot_loader.sv
// Randomized scoreboard bench for cvp_boot_loader: frames are built from the
// framing rules, expected memory writes are queued and a monitor checks them.
module tb_cvp_boot_loader;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] CoreAddr;
  logic        CoreRD;
  logic        CoreWR;
  logic [15:0] CoreDataOut;
  logic [15:0] MemAddr;
  logic        MemRD;
  logic        MemWR;
  logic [15:0] MemDataOut;
  logic        CoreReset;
  logic        Done;
  logic        Error;

  always #5 Clk = ~Clk;

  cvp_boot_loader #(.SYNC_BYTE(8'hA5), .HOLD_CYCLES(4)) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .CoreAddr    (CoreAddr),
    .CoreRD      (CoreRD),
    .CoreWR      (CoreWR),
    .CoreDataOut (CoreDataOut),
    .MemAddr     (MemAddr),
    .MemRD       (MemRD),
    .MemWR       (MemWR),
    .MemDataOut  (MemDataOut),
    .CoreReset   (CoreReset),
    .Done        (Done),
    .Error       (Error)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [15:0] words_q[$];
  int          total = 0;
  int          bad = 0;
  int          gap_max = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every loader write must match the head of the expected queue.
  always @(negedge Clk) begin
    if (Reset_n === 1'b1 && Done === 1'b0 && MemWR === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %h data %h want no write", MemAddr, MemDataOut);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {16'h0, MemAddr}, {16'h0, mon_e.a});
        check("wr_data", {16'h0, MemDataOut}, {16'h0, mon_e.d});
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 100) begin
      cycle();
      k++;
    end
    if (k >= 100) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1");
    end else begin
      cycle();
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) cycle();
  endtask

  // Builds a frame from words_q; expected writes go to the scoreboard first.
  task automatic send_frame(input logic [15:0] addr, input bit corrupt);
    logic [7:0]  bytes[$];
    logic [7:0]  csum;
    logic [15:0] n;
    logic [15:0] wa;
    n = 16'(words_q.size());
    bytes.push_back(8'hA5);
    bytes.push_back(addr[15:8]);
    bytes.push_back(addr[7:0]);
    bytes.push_back(n[15:8]);
    bytes.push_back(n[7:0]);
    foreach (words_q[i]) begin
      bytes.push_back(words_q[i][15:8]);
      bytes.push_back(words_q[i][7:0]);
      wa = addr + 16'(i);
      exp_q.push_back('{a: wa, d: words_q[i]});
    end
    csum = 8'h00;
    for (int i = 1; i < bytes.size(); i++) csum ^= bytes[i];
    if (corrupt) csum ^= 8'h5A;
    bytes.push_back(csum);
    foreach (bytes[i])
      send_byte(bytes[i], (i == bytes.size() - 1) ? 0 : int'($urandom_range(gap_max, 0)));
  endtask

  task automatic random_words(input int n);
    words_q.delete();
    for (int i = 0; i < n; i++) words_q.push_back(16'($urandom));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"},  {31'h0, in_ready}, 32'h1);
    check({tag, "_MemAddr"},   {16'h0, MemAddr}, 32'h0);
    check({tag, "_MemRD"},     {31'h0, MemRD}, 32'h0);
    check({tag, "_MemWR"},     {31'h0, MemWR}, 32'h0);
    check({tag, "_MemData"},   {16'h0, MemDataOut}, 32'h0);
    check({tag, "_CoreReset"}, {31'h0, CoreReset}, 32'h1);
    check({tag, "_Done"},      {31'h0, Done}, 32'h0);
    check({tag, "_Error"},     {31'h0, Error}, 32'h0);
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    #2;
    check_reset_values("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    cycle();
  endtask

  task automatic run_go(input logic exp_err);
    int n;
    int k;
    words_q.delete();
    send_frame(16'h0000, 1'b0);
    n = 0;
    k = 0;
    while (!Done && k < 50) begin
      if (CoreReset && !in_ready) n++;
      cycle();
      k++;
    end
    check("hold_cycles", n, 4);
    check("run_Done", {31'h0, Done}, 32'h1);
    check("run_CoreReset", {31'h0, CoreReset}, 32'h0);
    check("run_in_ready", {31'h0, in_ready}, 32'h0);
    check("run_Error", {31'h0, Error}, {31'h0, exp_err});
    for (int i = 0; i < 4; i++) begin
      CoreAddr    = 16'($urandom);
      CoreRD      = 1'($urandom);
      CoreWR      = 1'($urandom);
      CoreDataOut = 16'($urandom);
      in_valid    = 1'b1;
      in_data     = 8'hA5;
      #1;
      check("mux_addr", {16'h0, MemAddr}, {16'h0, CoreAddr});
      check("mux_rd", {31'h0, MemRD}, {31'h0, CoreRD});
      check("mux_wr", {31'h0, MemWR}, {31'h0, CoreWR});
      check("mux_data", {16'h0, MemDataOut}, {16'h0, CoreDataOut});
      cycle();
    end
    in_valid = 1'b0;
    check("run_stays_Done", {31'h0, Done}, 32'h1);
    check("run_stays_in_ready", {31'h0, in_ready}, 32'h0);
    CoreRD = 1'b1;
    CoreWR = 1'b1;
  endtask

  initial begin
    Reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    CoreAddr    = 16'hBEEF;
    CoreRD      = 1'b1;
    CoreWR      = 1'b1;
    CoreDataOut = 16'h1357;
    #12;
    check_reset_values("por");
    @(negedge Clk);
    Reset_n = 1'b1;
    cycle();

    // Fixed two-word frame, back-to-back bytes.
    gap_max = 0;
    words_q = '{16'h1234, 16'hABCD};
    send_frame(16'h0010, 1'b0);
    repeat (3) cycle();
    check("seg1_drained", exp_q.size(), 0);
    check("seg1_CoreReset", {31'h0, CoreReset}, 32'h1);
    check("seg1_in_ready", {31'h0, in_ready}, 32'h1);
    check("seg1_Done", {31'h0, Done}, 32'h0);

    // Random segments with idle gaps, plus an address wrap.
    gap_max = 3;
    for (int f = 0; f < 4; f++) begin
      random_words(int'($urandom_range(5, 1)));
      send_frame(16'($urandom), 1'b0);
    end
    random_words(2);
    send_frame(16'hFFFF, 1'b0);
    repeat (3) cycle();
    check("rand_drained", exp_q.size(), 0);
    check("rand_Error", {31'h0, Error}, 32'h0);

    // Reset after DATA_H: no write, then junk is dropped until SYNC.
    gap_max = 0;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h20, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    apply_reset();
    check("midreset_drained", exp_q.size(), 0);
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    words_q = '{16'hC0DE};
    send_frame(16'h0040, 1'b0);
    repeat (3) cycle();
    check("junk_drained", exp_q.size(), 0);

    run_go(1'b0);

    // Checksum failure path, recovery with SYNC, then GO with Error sticky.
    apply_reset();
    gap_max = 2;
    random_words(2);
    send_frame(16'h0200, 1'b1);
    repeat (2) cycle();
    check("err_Error", {31'h0, Error}, 32'h1);
    check("err_CoreReset", {31'h0, CoreReset}, 32'h1);
    check("err_in_ready", {31'h0, in_ready}, 32'h1);
    random_words(1);
    send_frame(16'h0100, 1'b0);
    repeat (2) cycle();
    check("err_recover_drained", exp_q.size(), 0);
    check("err_sticky", {31'h0, Error}, 32'h1);
    run_go(1'b1);

    check("final_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
